// File: rtl/hac_pkg.sv
// Shared types and helpers for the Hadamard accumulator drain path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hac_pkg;

  // Tile dimension; also the number of beats per drained frame.
  localparam int N = 16;

  // Legal range of the output round-and-shift amount.
  localparam int unsigned SHIFT_MIN = 0;
  localparam int unsigned SHIFT_MAX = 8;

  // Complex sample: signed 16-bit real and imaginary parts.
  typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] i;
  } complex_t;

  typedef complex_t [N-1:0]        line_t;
  typedef complex_t [N-1:0][N-1:0] tile_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

  // Round-half-up arithmetic right shift. The sum is formed in 17 bits so the
  // rounding bias cannot wrap; after shifting by at least 1 it fits 16 bits.
  function automatic logic signed [15:0] round_shift(input logic signed [15:0] x,
                                                     input int unsigned sh);
    logic signed [16:0] w;
    if (sh == 0) begin
      return x;
    end
    w = {x[15], x};
    w = w + (17'sd1 <<< (sh - 1));
    w = w >>> sh;
    return w[15:0];
  endfunction

endpackage

// File: rtl/hac_tile_drain_if.sv
// Bundle between the accumulator/IFFT environment and the tile drain.
// Latency: n/a (wiring only).
// Backpressure: line_ready from the consumer stalls line_valid beats.
interface hac_tile_drain_if;
  import hac_pkg::*;

  tile_t      tile_in;
  logic       tile_valid;
  line_t      line_out;
  logic       line_valid;
  logic       line_ready;
  logic       line_last;
  logic [3:0] line_index;
  logic       busy;
  logic       overrun;

  // Environment side: supplies tiles, consumes lines.
  modport master (
    output tile_in, tile_valid, line_ready,
    input  line_out, line_valid, line_last, line_index, busy, overrun
  );

  // Drain side.
  modport slave (
    input  tile_in, tile_valid, line_ready,
    output line_out, line_valid, line_last, line_index, busy, overrun
  );

endinterface

// File: rtl/hac_tile_drain_round_shift.sv
// Per-element rounding arithmetic right shift of both complex components.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; follows its input directly.
module complex_round_shift
  import hac_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  complex_t x,
  output complex_t y
);

  // Out-of-range shift requests saturate at the widest legal shift.
  localparam int unsigned EFF_SHIFT = (SHIFT > SHIFT_MAX) ? SHIFT_MAX : SHIFT;

  assign y.r = round_shift(x.r, EFF_SHIFT);
  assign y.i = round_shift(x.i, EFF_SHIFT);

endmodule

// File: rtl/hac_tile_drain.sv
// Snapshots a finished 16x16 complex tile and streams it one line per beat.
// Latency: 1 cycle from tile_valid to first line_valid; zero-bubble back-to-back.
// Backpressure: beats advance only on line_valid && line_ready; outputs held
// while stalled; a tile arriving mid-frame is dropped and sets sticky overrun.
// Build option: HAC_DRAIN_COLMAJOR_EN emits columns instead of rows.
module hac_tile_drain
  import hac_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  hac_tile_drain_if.slave  bus
);

  drain_state_t state;
  logic [3:0]   beat;
  tile_t        shadow;
  tile_t        cap;
  logic         overrun_q;
  logic         last_beat;
  line_t        raw_line;
  wire line_t   shaped_line;

  assign last_beat = (beat == 4'(N - 1));

  // Reorder the incoming tile at capture time so that every beat reads one
  // shadow row, whichever emission order is built.
  always_comb begin
    cap = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
`ifdef HAC_DRAIN_COLMAJOR_EN
        cap[k][j] = bus.tile_in[j][k];
`else
        cap[k][j] = bus.tile_in[k][j];
`endif
      end
    end
  end

  // Frame FSM: capture, beat counting on handshakes, overrun tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      shadow    <= '0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.tile_valid) begin
            shadow <= cap;
            beat   <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          // Only a tile coinciding with the final handshake can be accepted.
          if (bus.tile_valid && !(bus.line_ready && last_beat)) begin
            overrun_q <= 1'b1;
          end
          if (bus.line_ready) begin
            if (last_beat) begin
              beat <= '0;
              if (bus.tile_valid) begin
                shadow <= cap;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat <= beat + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Current line straight from the shadow bank; no extra pipeline stage.
  always_comb begin
    raw_line = shadow[beat];
  end

  for (genvar j = 0; j < N; j++) begin : g_round
    complex_round_shift #(.SHIFT(SHIFT)) u_round (
      .x (raw_line[j]),
      .y (shaped_line[j])
    );
  end

  assign bus.line_out   = shaped_line;
  assign bus.line_valid = (state == STREAM);
  assign bus.busy       = (state == STREAM);
  assign bus.line_last  = (state == STREAM) && last_beat;
  assign bus.line_index = beat;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_hac_tile_drain.sv
// Self-checking bench for hac_tile_drain: two instances (SHIFT=0 and SHIFT=2)
// share stimulus and are compared each cycle against a queue-of-lines model.
// Honours HAC_DRAIN_COLMAJOR_EN for the expected emission order.
module tb_hac_tile_drain;
  import hac_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  tile_t tile;
  logic  tv;
  logic  rdy;

  always #5 clk = ~clk;

  hac_tile_drain_if if0 ();
  hac_tile_drain_if if2 ();

  assign if0.tile_in    = tile;
  assign if0.tile_valid = tv;
  assign if0.line_ready = rdy;
  assign if2.tile_in    = tile;
  assign if2.tile_valid = tv;
  assign if2.line_ready = rdy;

  hac_tile_drain #(.SHIFT(0)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  hac_tile_drain #(.SHIFT(2)) dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

  int checks = 0;
  int errors = 0;
  int handshakes = 0;

  // Reference model: lines still owed to the consumer, oldest first.
  line_t q_dat[$];
  int    q_idx[$];
  bit    m_ovr;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd(input logic signed [15:0] x, input int s);
    int v;
    if (s == 0) return x;
    v = int'(x) + (1 << (s - 1));
    v = v >>> s;
    return v[15:0];
  endfunction

  function automatic line_t exp_line(input line_t l, input int s);
    line_t e;
    for (int j = 0; j < N; j++) begin
      e[j].r = rnd(l[j].r, s);
      e[j].i = rnd(l[j].i, s);
    end
    return e;
  endfunction

  task automatic push_tile(input tile_t t);
    line_t l;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
`ifdef HAC_DRAIN_COLMAJOR_EN
        l[j] = t[j][k];
`else
        l[j] = t[k][j];
`endif
      end
      q_dat.push_back(l);
      q_idx.push_back(k);
    end
  endtask

  task automatic compare();
    bit v;
    v = (q_dat.size() > 0);
    check("valid0", if0.line_valid, v);
    check("valid2", if2.line_valid, v);
    check("busy0", if0.busy, v);
    check("busy2", if2.busy, v);
    check("last0", if0.line_last, v && q_dat.size() == 1);
    check("last2", if2.line_last, v && q_dat.size() == 1);
    check("ovr0", if0.overrun, m_ovr);
    check("ovr2", if2.overrun, m_ovr);
    if (v) begin
      check("index0", if0.line_index, q_idx[0]);
      check("index2", if2.line_index, q_idx[0]);
      check("line0", if0.line_out, exp_line(q_dat[0], 0));
      check("line2", if2.line_out, exp_line(q_dat[0], 2));
    end
  endtask

  // Advance the model on the current inputs, take one clock edge, compare.
  task automatic step();
    if (q_dat.size() > 0 && rdy) begin
      void'(q_dat.pop_front());
      void'(q_idx.pop_front());
      handshakes++;
    end
    if (tv) begin
      if (q_dat.size() == 0) push_tile(tile);
      else m_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic rand_tile();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        tile[a][b] = complex_t'($urandom());
  endtask

  task automatic start_frame();
    tv = 1'b1;
    step();
    tv = 1'b0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out0"}, if0.line_out, '0);
    check({tag, "_out2"}, if2.line_out, '0);
    check({tag, "_vld"}, {if0.line_valid, if2.line_valid}, 2'b00);
    check({tag, "_last"}, {if0.line_last, if2.line_last}, 2'b00);
    check({tag, "_idx"}, {if0.line_index, if2.line_index}, 8'h00);
    check({tag, "_busy"}, {if0.busy, if2.busy}, 2'b00);
    check({tag, "_ovr"}, {if0.overrun, if2.overrun}, 2'b00);
  endtask

  initial begin
    rst  = 1'b1;
    tv   = 1'b0;
    rdy  = 1'b0;
    tile = '0;
    m_ovr = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare();

    // Basic ordered pattern.
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        tile[a][b].r = 16'(16 * a + b);
        tile[a][b].i = 16'(-(16 * a + b));
      end
    rdy = 1'b1;
    start_frame();
    drain(3);
    check("b3_index", if0.line_index, 4'd3);
`ifdef HAC_DRAIN_COLMAJOR_EN
    check("b3_elem5", if0.line_out[5], {16'sd83, -16'sd83});
`else
    check("b3_elem5", if0.line_out[5], {16'sd53, -16'sd53});
`endif
    drain(12);
    check("b15_last", if0.line_last, 1'b1);
    drain(2);
    check("basic_idle", if0.busy, 1'b0);

    // Back-to-back: new tile coincides with the final handshake.
    rand_tile();
    start_frame();
    drain(15);
    rand_tile();
    start_frame();
    check("b2b_index", if0.line_index, 4'd0);
    check("b2b_ovr", if0.overrun, 1'b0);
    drain(17);

    // Rounding corner values on the diagonal (same beat in either order).
    rand_tile();
    tile[0][0].r = 16'sd7;
    tile[0][0].i = -16'sd7;
    tile[1][1].r = 16'sd32767;
    tile[1][1].i = 16'sh8000;
    start_frame();
    check("rnd_small", if2.line_out[0], {16'sd2, -16'sd2});
    step();
    check("rnd_big", if2.line_out[1], {16'sd8192, -16'sd8192});
    drain(16);

    // Backpressure pattern 1,0,0,1.
    rand_tile();
    start_frame();
    handshakes = 0;
    for (int c = 0; c < 80; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      step();
    end
    check("bp_handshakes", handshakes, 16);
    rdy = 1'b1;

    // Overrun: second tile arrives at beat 7 and is dropped.
    rand_tile();
    start_frame();
    drain(7);
    rand_tile();
    start_frame();
    drain(12);
    check("ovr_sticky", if0.overrun, 1'b1);
    check("ovr_idle", if0.busy, 1'b0);

    // Reset mid-stream at beat 9.
    rand_tile();
    start_frame();
    drain(9);
    rst = 1'b1;
    q_dat.delete();
    q_idx.delete();
    m_ovr = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #1;
    check_zero_outputs("midrst_hold");
    rst = 1'b0;
    rand_tile();
    start_frame();
    check("rst_new_index", if0.line_index, 4'd0);
    drain(17);

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      tv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (tv) rand_tile();
      step();
    end
    tv  = 1'b0;
    rdy = 1'b1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
